// File: rtl/snake_pkg.sv
// Shared types and constants for the snake-game sprite path.
`timescale 1ns/1ps
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_R = 2'd0,
        DIR_D = 2'd1,
        DIR_U = 2'd2,
        DIR_L = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAW  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ERASE = 3'd3,
        ST_MOVE  = 3'd4
    } state_t;

    localparam int unsigned EDGE_STOP   = 0;
    localparam int unsigned EDGE_WRAP   = 1;
    localparam int unsigned EDGE_BOUNCE = 2;

    localparam int unsigned SCREEN_X = 160;
    localparam int unsigned SCREEN_Y = 120;

    // Pixel coordinate widths and the widened move-arithmetic width
    localparam int unsigned XW = 8;
    localparam int unsigned YW = 7;
    localparam int unsigned MW = 9;

    // R<->L and D<->U are bitwise complements in this encoding
    function automatic dir_t dir_opposite(input dir_t d);
        return dir_t'(~d);
    endfunction

endpackage

// File: rtl/rect_scanner.sv
// Raster scan over an XDIM x YDIM rectangle, one pixel per enabled cycle.
`timescale 1ns/1ps
module rect_scanner
    import snake_pkg::*;
#(
    parameter int unsigned XDIM = 10,
    parameter int unsigned YDIM = 10
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          start,
    input  logic          en,
    output logic [XW-1:0] xc,
    output logic [YW-1:0] yc,
    output logic          last
);

    localparam logic [XW-1:0] XLAST = XW'(XDIM - 1);
    localparam logic [YW-1:0] YLAST = YW'(YDIM - 1);

    // Final pixel of the rectangle
    assign last = (xc == XLAST) && (yc == YLAST);

    // Column/row counters; wrap to origin after the last pixel so the next scan starts clean
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            xc <= '0;
            yc <= '0;
        end else if (start) begin
            xc <= '0;
            yc <= '0;
        end else if (en) begin
            if (xc == XLAST) begin
                xc <= '0;
                yc <= last ? '0 : yc + YW'(1);
            end else begin
                xc <= xc + XW'(1);
            end
        end
    end

endmodule

// File: rtl/sprite_mover.sv
// Rectangular sprite engine: draw, wait for frame tick, erase, move, redraw.
`timescale 1ns/1ps
module sprite_mover
    import snake_pkg::*;
#(
    parameter int unsigned XSCREEN   = SCREEN_X,
    parameter int unsigned YSCREEN   = SCREEN_Y,
    parameter int unsigned XDIM      = 10,
    parameter int unsigned YDIM      = 10,
    parameter int unsigned X0        = 39,
    parameter int unsigned Y0        = 59,
    parameter int unsigned STEP      = 1,
    parameter int unsigned EDGE_MODE = EDGE_STOP
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          load,
    input  logic          go,
    input  logic          tick,
    input  logic [3:0]    dir_req,
    input  logic [2:0]    colour,
    input  logic [2:0]    bg_colour,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [2:0]    vga_colour,
    output logic          plot,
    output logic [XW-1:0] x_pos,
    output logic [YW-1:0] y_pos,
    output logic [1:0]    dir,
    output logic          edge_hit,
    output logic          busy
);

    localparam int unsigned XMAX = XSCREEN - XDIM;
    localparam int unsigned YMAX = YSCREEN - YDIM;

    localparam logic [MW-1:0] XMAX_M = MW'(XMAX);
    localparam logic [MW-1:0] YMAX_M = MW'(YMAX);
    localparam logic [MW-1:0] STEP_M = MW'(STEP);
    localparam logic [XW-1:0] X0_P   = XW'(X0);
    localparam logic [YW-1:0] Y0_P   = YW'(Y0);

    state_t        state;
    dir_t          cur_dir;
    dir_t          req_dir;
    dir_t          dir_filt;
    logic          req_valid;
    logic [XW-1:0] xc;
    logic [YW-1:0] yc;
    logic          scan_last;
    logic          scan_start;
    logic          scan_en;
    logic [MW-1:0] x_ext;
    logic [MW-1:0] y_ext;
    logic [MW-1:0] nx;
    logic [MW-1:0] ny;
    logic          blocked;

    assign dir   = cur_dir;
    assign vga_x = XW'(x_pos + xc);
    assign vga_y = YW'(y_pos + yc);
    assign x_ext = MW'(x_pos);
    assign y_ext = MW'(y_pos);

    assign scan_start = load || ((state == ST_IDLE) && go && tick);
    assign scan_en    = (state == ST_DRAW) || (state == ST_ERASE);

    rect_scanner #(
        .XDIM (XDIM),
        .YDIM (YDIM)
    ) u_scan (
        .Clock  (Clock),
        .Resetn (Resetn),
        .start  (scan_start),
        .en     (scan_en),
        .xc     (xc),
        .yc     (yc),
        .last   (scan_last)
    );

    // Prioritised direction request with reversal filter
    always_comb begin
        req_dir   = cur_dir;
        req_valid = 1'b0;
        if (dir_req[0]) begin
            req_dir   = DIR_R;
            req_valid = 1'b1;
        end else if (dir_req[1]) begin
            req_dir   = DIR_D;
            req_valid = 1'b1;
        end else if (dir_req[2]) begin
            req_dir   = DIR_U;
            req_valid = 1'b1;
        end else if (dir_req[3]) begin
            req_dir   = DIR_L;
            req_valid = 1'b1;
        end
        dir_filt = (req_valid && (req_dir != dir_opposite(cur_dir))) ? req_dir : cur_dir;
    end

    // Next position in 9 bits with edge handling; BOUNCE leaves the position untouched
    always_comb begin
        nx      = x_ext;
        ny      = y_ext;
        blocked = 1'b0;
        case (cur_dir)
            DIR_R: begin
                if (x_ext + STEP_M > XMAX_M) begin
                    blocked = 1'b1;
                    if (EDGE_MODE == EDGE_STOP)      nx = XMAX_M;
                    else if (EDGE_MODE == EDGE_WRAP) nx = '0;
                end else begin
                    nx = x_ext + STEP_M;
                end
            end
            DIR_L: begin
                if (x_ext < STEP_M) begin
                    blocked = 1'b1;
                    if (EDGE_MODE == EDGE_STOP)      nx = '0;
                    else if (EDGE_MODE == EDGE_WRAP) nx = XMAX_M;
                end else begin
                    nx = x_ext - STEP_M;
                end
            end
            DIR_D: begin
                if (y_ext + STEP_M > YMAX_M) begin
                    blocked = 1'b1;
                    if (EDGE_MODE == EDGE_STOP)      ny = YMAX_M;
                    else if (EDGE_MODE == EDGE_WRAP) ny = '0;
                end else begin
                    ny = y_ext + STEP_M;
                end
            end
            default: begin
                if (y_ext < STEP_M) begin
                    blocked = 1'b1;
                    if (EDGE_MODE == EDGE_STOP)      ny = '0;
                    else if (EDGE_MODE == EDGE_WRAP) ny = YMAX_M;
                end else begin
                    ny = y_ext - STEP_M;
                end
            end
        endcase
    end

    // Sequencer with registered pixel outputs; load aborts any scan without erasing
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state      <= ST_IDLE;
            cur_dir    <= DIR_R;
            x_pos      <= X0_P;
            y_pos      <= Y0_P;
            plot       <= 1'b0;
            edge_hit   <= 1'b0;
            busy       <= 1'b0;
            vga_colour <= '0;
        end else if (load) begin
            state    <= ST_IDLE;
            cur_dir  <= DIR_R;
            x_pos    <= X0_P;
            y_pos    <= Y0_P;
            plot     <= 1'b0;
            edge_hit <= 1'b0;
            busy     <= 1'b0;
        end else begin
            edge_hit <= 1'b0;
            cur_dir  <= dir_filt;
            case (state)
                ST_IDLE: begin
                    if (go && tick) begin
                        state      <= ST_DRAW;
                        plot       <= 1'b1;
                        busy       <= 1'b1;
                        vga_colour <= colour;
                    end
                end
                ST_DRAW: begin
                    vga_colour <= colour;
                    if (scan_last) begin
                        state <= ST_WAIT;
                        plot  <= 1'b0;
                        busy  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (tick) begin
                        state      <= ST_ERASE;
                        plot       <= 1'b1;
                        busy       <= 1'b1;
                        vga_colour <= bg_colour;
                    end else if (!go) begin
                        state <= ST_IDLE;
                    end
                end
                ST_ERASE: begin
                    vga_colour <= bg_colour;
                    if (scan_last) begin
                        state <= ST_MOVE;
                        plot  <= 1'b0;
                    end
                end
                ST_MOVE: begin
                    x_pos      <= XW'(nx);
                    y_pos      <= YW'(ny);
                    edge_hit   <= blocked;
                    if (blocked && (EDGE_MODE == EDGE_BOUNCE)) begin
                        cur_dir <= dir_opposite(cur_dir);
                    end
                    state      <= ST_DRAW;
                    plot       <= 1'b1;
                    vga_colour <= colour;
                end
                default: begin
                    state <= ST_IDLE;
                    plot  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: scan timing, move, edges, direction filter, abort.
`timescale 1ns/1ps
module tb_sprite_mover;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic       load, go, tick;
    logic [3:0] dir_req_m, dir_req_e, dir_req_b;
    logic [2:0] colour, bg_colour;

    logic [7:0] m_vga_x, s_vga_x, w_vga_x, b_vga_x;
    logic [6:0] m_vga_y, s_vga_y, w_vga_y, b_vga_y;
    logic [2:0] m_col, s_col, w_col, b_col;
    logic       m_plot, s_plot, w_plot, b_plot;
    logic [7:0] m_x, s_x, w_x, b_x;
    logic [6:0] m_y, s_y, w_y, b_y;
    logic [1:0] m_dir, s_dir, w_dir, b_dir;
    logic       m_edge, s_edge, w_edge, b_edge;
    logic       m_busy, s_busy, w_busy, b_busy;

    int checks = 0;
    int errors = 0;
    int pcount;

    always #5 Clock = ~Clock;

    sprite_mover u_main (
        .Clock(Clock), .Resetn(Resetn), .load(load), .go(go), .tick(tick),
        .dir_req(dir_req_m), .colour(colour), .bg_colour(bg_colour),
        .vga_x(m_vga_x), .vga_y(m_vga_y), .vga_colour(m_col), .plot(m_plot),
        .x_pos(m_x), .y_pos(m_y), .dir(m_dir), .edge_hit(m_edge), .busy(m_busy)
    );

    sprite_mover #(.EDGE_MODE(0), .X0(150)) u_stop (
        .Clock(Clock), .Resetn(Resetn), .load(load), .go(go), .tick(tick),
        .dir_req(dir_req_e), .colour(colour), .bg_colour(bg_colour),
        .vga_x(s_vga_x), .vga_y(s_vga_y), .vga_colour(s_col), .plot(s_plot),
        .x_pos(s_x), .y_pos(s_y), .dir(s_dir), .edge_hit(s_edge), .busy(s_busy)
    );

    sprite_mover #(.EDGE_MODE(1), .X0(150)) u_wrap (
        .Clock(Clock), .Resetn(Resetn), .load(load), .go(go), .tick(tick),
        .dir_req(dir_req_e), .colour(colour), .bg_colour(bg_colour),
        .vga_x(w_vga_x), .vga_y(w_vga_y), .vga_colour(w_col), .plot(w_plot),
        .x_pos(w_x), .y_pos(w_y), .dir(w_dir), .edge_hit(w_edge), .busy(w_busy)
    );

    sprite_mover #(.EDGE_MODE(2), .Y0(0)) u_bnc (
        .Clock(Clock), .Resetn(Resetn), .load(load), .go(go), .tick(tick),
        .dir_req(dir_req_b), .colour(colour), .bg_colour(bg_colour),
        .vga_x(b_vga_x), .vga_y(b_vga_y), .vga_colour(b_col), .plot(b_plot),
        .x_pos(b_x), .y_pos(b_y), .dir(b_dir), .edge_hit(b_edge), .busy(b_busy)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Advance until the main instance leaves the busy states, bounded
    task automatic run_until_idle(input string tag);
        int n;
        n = 0;
        while (m_busy && n < 300) begin
            step();
            n++;
        end
        check(tag, int'(m_busy), 0);
    endtask

    initial begin
        Resetn    = 1'b0;
        load      = 1'b0;
        go        = 1'b0;
        tick      = 1'b0;
        dir_req_m = 4'b0000;
        dir_req_e = 4'b0000;
        dir_req_b = 4'b0100;
        colour    = 3'b101;
        bg_colour = 3'b010;
        step();
        step();

        check("rst_x", int'(m_x), 39);
        check("rst_y", int'(m_y), 59);
        check("rst_dir", int'(m_dir), 0);
        check("rst_plot", int'(m_plot), 0);
        check("rst_edge", int'(m_edge), 0);
        check("rst_col", int'(m_col), 0);
        check("rst_busy", int'(m_busy), 0);

        Resetn = 1'b1;
        step();
        load = 1'b1;
        step();
        load = 1'b0;
        go   = 1'b1;
        step();

        // First draw
        tick = 1'b1;
        step();
        tick = 1'b0;
        pcount = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_plot) pcount++;
            if (i == 0) begin
                check("draw_first_x", int'(m_vga_x), 39);
                check("draw_first_y", int'(m_vga_y), 59);
                check("draw_col", int'(m_col), 5);
            end
            if (i == 99) begin
                check("draw_last_x", int'(m_vga_x), 48);
                check("draw_last_y", int'(m_vga_y), 68);
            end
            step();
        end
        check("draw_len", pcount, 100);
        check("wait_plot", int'(m_plot), 0);
        check("wait_busy", int'(m_busy), 0);
        step();
        check("wait_hold", int'(m_plot), 0);

        // Erase, move, redraw
        tick = 1'b1;
        step();
        tick = 1'b0;
        pcount = 0;
        for (int i = 0; i < 100; i++) begin
            if (m_plot) pcount++;
            if (i == 50) check("erase_col", int'(m_col), 2);
            step();
        end
        check("erase_len", pcount, 100);
        check("move_plot", int'(m_plot), 0);
        check("move_busy", int'(m_busy), 1);
        step();
        check("redraw_x", int'(m_vga_x), 40);
        check("redraw_y", int'(m_vga_y), 59);
        check("redraw_plot", int'(m_plot), 1);
        check("main_edge", int'(m_edge), 0);
        check("stop_x", int'(s_x), 150);
        check("stop_edge", int'(s_edge), 1);
        check("wrap_x", int'(w_x), 0);
        check("wrap_edge", int'(w_edge), 1);
        check("bnc_y", int'(b_y), 0);
        check("bnc_dir", int'(b_dir), 1);
        check("bnc_edge", int'(b_edge), 1);
        step();
        check("stop_edge_once", int'(s_edge), 0);

        // Second frame: bounce moves back down
        run_until_idle("wait2");
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (101) step();
        check("bnc_y2", int'(b_y), 1);
        check("bnc_dir2", int'(b_dir), 1);
        check("main_x2", int'(m_x), 41);

        // Direction filter
        run_until_idle("wait3");
        dir_req_m = 4'b1000; step(); check("dir_rev_ignored", int'(m_dir), 0);
        dir_req_m = 4'b0010; step(); check("dir_down", int'(m_dir), 1);
        dir_req_m = 4'b1000; step(); check("dir_left", int'(m_dir), 3);
        dir_req_m = 4'b0110; step(); check("dir_prio", int'(m_dir), 1);
        dir_req_m = 4'b0000; step(); check("dir_keep", int'(m_dir), 1);
        dir_req_m = 4'b0001; step(); check("dir_right", int'(m_dir), 0);
        dir_req_m = 4'b0000;

        // Back to IDLE, then abort a draw with load
        go = 1'b0;
        step();
        go   = 1'b1;
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("idle_draw_x", int'(m_vga_x), 41);
        check("idle_draw_col", int'(m_col), 5);
        repeat (37) step();
        check("px37_x", int'(m_vga_x), 48);
        check("px37_y", int'(m_vga_y), 62);
        load = 1'b1;
        step();
        load = 1'b0;
        check("load_plot", int'(m_plot), 0);
        check("load_busy", int'(m_busy), 0);
        check("load_x", int'(m_x), 39);
        check("load_y", int'(m_y), 59);
        check("load_dir", int'(m_dir), 0);
        step();
        check("load_idle_hold", int'(m_plot), 0);

        // Same abort point via asynchronous reset
        tick = 1'b1;
        step();
        tick = 1'b0;
        run_until_idle("wait4");
        tick = 1'b1;
        step();
        tick = 1'b0;
        repeat (101) step();
        check("pre_rst_x", int'(m_x), 40);
        repeat (37) step();
        check("pre_rst_plot", int'(m_plot), 1);
        Resetn = 1'b0;
        #2;
        check("arst_plot", int'(m_plot), 0);
        check("arst_busy", int'(m_busy), 0);
        check("arst_x", int'(m_x), 39);
        check("arst_y", int'(m_y), 59);
        check("arst_dir", int'(m_dir), 0);
        check("arst_vga_x", int'(m_vga_x), 39);
        #1;
        Resetn = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
